// File: rtl/led_user_turn_pkg.sv
//------------------------------------------------------------------------------
// led_user_turn_pkg : shared types and constants for the memory-game round sequencer
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package led_user_turn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    INPUT = 2'd2
  } state_t;

  localparam logic [1:0] GAME_OVER = 2'd0;

  // Indexed by rounds remaining; round 0 is the game-over blank pattern.
  localparam logic [9:0] PATTERN [0:3] = '{10'h000, 10'h30F, 10'h0F0, 10'h2AA};

endpackage

`default_nettype wire

// File: rtl/led_user_turn_adder.sv
//------------------------------------------------------------------------------
// adder_2bit : combinational 2-bit ripple-carry adder
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adder_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic [2:0] w_carry;

  assign w_carry[0] = cin;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = w_carry[2];

endmodule

`default_nettype wire

// File: rtl/led_user_turn.sv
//------------------------------------------------------------------------------
// led_user_turn : shows the round pattern, opens the input window, captures my_sol
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module led_user_turn
  import led_user_turn_pkg::*;
#(
  parameter int unsigned LED_CYCLES  = 100_000_000,
  parameter int unsigned USER_CYCLES = 300_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] testcase,
  input  logic [1:0] reg_score,
  input  logic       compare_turn_finish,
  input  logic [9:0] switch,
  output logic [9:0] led,
  output logic       led_is_finish,
  output logic       user_turn_finish,
  output logic [9:0] my_sol,
  output logic [1:0] testcase_next
);

  localparam logic [CNT_W-1:0] C_LED_CNT  = CNT_W'(LED_CYCLES);
  localparam logic [CNT_W-1:0] C_USER_CNT = CNT_W'(USER_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_armed;
  logic             w_armed_nxt;
  logic [9:0]       r_led;
  logic [9:0]       w_led_nxt;
  logic [9:0]       r_my_sol;
  logic             r_led_is_finish;
  logic             w_lif_nxt;
  logic             r_user_turn_finish;
  logic             w_utf_nxt;
  logic             w_capture;
  logic [CNT_W-1:0] w_shifted;
  logic [CNT_W-1:0] w_dur;
  logic             w_cnt_last;
  logic             w_unused_cout;

  // Higher scores shorten the display, but it never drops below one cycle.
  assign w_shifted  = C_LED_CNT >> reg_score;
  assign w_dur      = (w_shifted == '0) ? C_ONE : w_shifted;
  assign w_cnt_last = (r_cnt == C_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
    w_lif_nxt   = 1'b0;
    w_utf_nxt   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if ((r_armed || compare_turn_finish) && (testcase != GAME_OVER)) begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = w_dur;
          w_armed_nxt = 1'b0;
        end
      end
      SHOW: begin
        w_cnt_nxt = r_cnt - C_ONE;
        if (w_cnt_last) begin
          w_state_nxt = INPUT;
          w_cnt_nxt   = C_USER_CNT;
          w_lif_nxt   = 1'b1;
        end
      end
      INPUT: begin
        w_cnt_nxt = r_cnt - C_ONE;
        if (w_cnt_last) begin
          w_state_nxt = IDLE;
          w_utf_nxt   = 1'b1;
          w_capture   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // LED register follows the next state so the pattern is visible exactly while in SHOW.
    w_led_nxt = (w_state_nxt == SHOW) ? PATTERN[testcase] : 10'h000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt              <= '0;
      r_armed            <= 1'b1;
      r_led              <= 10'h000;
      r_my_sol           <= 10'h000;
      r_led_is_finish    <= 1'b0;
      r_user_turn_finish <= 1'b0;
    end else begin
      r_cnt              <= w_cnt_nxt;
      r_armed            <= w_armed_nxt;
      r_led              <= w_led_nxt;
      r_led_is_finish    <= w_lif_nxt;
      r_user_turn_finish <= w_utf_nxt;
      if (w_capture) begin
        r_my_sol <= switch;
      end
    end
  end

  assign led              = r_led;
  assign led_is_finish    = r_led_is_finish;
  assign user_turn_finish = r_user_turn_finish;
  assign my_sol           = r_my_sol;

  // testcase - 1 expressed as testcase + 2'b10 + 1 (mod 4).
  adder_2bit u_dec (
    .a    (testcase),
    .b    (2'b10),
    .cin  (1'b1),
    .sum  (testcase_next),
    .cout (w_unused_cout)
  );

endmodule

`default_nettype wire

// File: tb/tb_led_user_turn.sv
//------------------------------------------------------------------------------
// tb_led_user_turn : directed self-checking bench for led_user_turn
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_user_turn;

  logic       clk;
  logic       reset;
  logic [1:0] testcase;
  logic [1:0] reg_score;
  logic       ctf;
  logic [9:0] switch_in;
  logic [9:0] led;
  logic       lif;
  logic       utf;
  logic [9:0] my_sol;
  logic [1:0] tcn;

  int n_tests = 0;
  int n_fail  = 0;

  led_user_turn #(
    .LED_CYCLES  (8),
    .USER_CYCLES (12),
    .CNT_W       (32)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .testcase            (testcase),
    .reg_score           (reg_score),
    .compare_turn_finish (ctf),
    .switch              (switch_in),
    .led                 (led),
    .led_is_finish       (lif),
    .user_turn_finish    (utf),
    .my_sol              (my_sol),
    .testcase_next       (tcn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the pattern to appear, then counts its consecutive cycles.
  // Optionally pulses compare_turn_finish after the poke-th SHOW cycle.
  task automatic run_show(input logic [9:0] pat, input int poke, output int dly, output int len);
    dly = 0;
    len = 0;
    @(negedge clk);
    ctf = 1'b0;
    while (led == 10'h000 && dly < 30) begin
      dly++;
      @(negedge clk);
    end
    while (led == pat && len < 40) begin
      len++;
      ctf = (len == poke);
      @(negedge clk);
    end
    ctf = 1'b0;
  endtask

  task automatic wait_utf(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!utf && n < 40);
  endtask

  task automatic quiet(input int cycles, output logic ok);
    ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ctf = 1'b0;
      if (led != 10'h000 || lif || utf) ok = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dly;
    int   len;
    int   n;
    logic ok;

    reset     = 1'b1;
    testcase  = 2'd3;
    reg_score = 2'd0;
    ctf       = 1'b0;
    switch_in = 10'h000;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_led", led, 10'h000);
    chk("rst_my_sol", my_sol, 10'h000);
    chk("rst_lif", lif, 1'b0);
    chk("rst_utf", utf, 1'b0);
    chk("tcn_3", tcn, 2'd2);

    // Reset start: pattern 2AA for 8 cycles
    reset = 1'b0;
    run_show(10'h2AA, 0, dly, len);
    chk("start_dly", dly, 0);
    chk("start_len", len, 8);
    chk("start_end_led", led, 10'h000);
    chk("start_lif", lif, 1'b1);
    chk("pre_cap_my_sol", my_sol, 10'h000);

    // Capture: switch only settles to 155 in the last INPUT cycle
    switch_in = 10'h3FF;
    ok = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (utf || lif) ok = 1'b0;
      if (k == 11) switch_in = 10'h155;
    end
    chk("input_quiet", ok, 1'b1);
    @(negedge clk);
    chk("cap_utf", utf, 1'b1);
    chk("cap_my_sol", my_sol, 10'h155);
    switch_in = 10'h000;
    quiet(10, ok);
    chk("post_cap_idle", ok, 1'b1);
    chk("cap_hold", my_sol, 10'h155);

    // Score scaling: 8 >> 2 = 2
    testcase  = 2'd2;
    reg_score = 2'd2;
    ctf       = 1'b1;
    run_show(10'h0F0, 0, dly, len);
    chk("sc2_dly", dly, 0);
    chk("sc2_len", len, 2);
    chk("sc2_lif", lif, 1'b1);
    wait_utf(n);
    chk("sc2_input_len", n, 12);

    // Trigger in the same cycle as user_turn_finish; 8 >> 3 = 1
    testcase  = 2'd1;
    reg_score = 2'd3;
    ctf       = 1'b1;
    run_show(10'h30F, 0, dly, len);
    chk("sc3_dly", dly, 0);
    chk("sc3_len", len, 1);
    wait_utf(n);
    chk("sc3_input_len", n, 12);

    // Game over
    testcase  = 2'd0;
    switch_in = 10'h3FF;
    ctf       = 1'b1;
    quiet(20, ok);
    chk("game_over_quiet", ok, 1'b1);
    #1;
    chk("tcn_0", tcn, 2'd3);
    testcase = 2'd1;
    #1;
    chk("tcn_1", tcn, 2'd0);
    testcase = 2'd2;
    #1;
    chk("tcn_2", tcn, 2'd1);

    // Ignored trigger mid-SHOW; 8 >> 1 = 4
    @(negedge clk);
    testcase  = 2'd3;
    reg_score = 2'd1;
    ctf       = 1'b1;
    run_show(10'h2AA, 2, dly, len);
    chk("ign_len", len, 4);
    wait_utf(n);
    chk("ign_input_len", n, 12);
    chk("ign_my_sol", my_sol, 10'h3FF);
    quiet(20, ok);
    chk("ign_no_extra_round", ok, 1'b1);

    // Reset mid-round during INPUT
    testcase  = 2'd2;
    reg_score = 2'd0;
    ctf       = 1'b1;
    run_show(10'h0F0, 0, dly, len);
    chk("rmr_len", len, 8);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmr_led", led, 10'h000);
    chk("rmr_my_sol", my_sol, 10'h000);
    chk("rmr_lif", lif, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rmr_restart_led", led, 10'h0F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_user_turn.md
# led_user_turn

Round sequencer for the 10-LED memory game. It shows the stored pattern for the current round on the LEDs for a score-dependent time. It then opens a fixed input window and captures the player's switch setting as `my_sol`. It sits between the top-level round/score registers and the comparator, and exports the decremented round count through an internal 2-bit adder.

## Interface
- `LED_CYCLES`, default 100_000_000: base display time in clocks; minimum 1.
- `USER_CYCLES`, default 300_000_000: input window length in clocks; minimum 1.
- `CNT_W`, default 32: width of the down-counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `testcase`  in  2: rounds remaining (3..1); 0 means the game is over.
- `reg_score`  in  2: current score.
- `compare_turn_finish`  in  1: one-cycle pulse from the comparator; starts the next round.
- `switch`  in  10: player input.
- `led`  out  10: registered LED drive.
- `led_is_finish`  out  1: one-cycle pulse, display phase done.
- `user_turn_finish`  out  1: one-cycle pulse, `my_sol` is valid.
- `my_sol`  out  10: captured switch value; held until the next capture.
- `testcase_next`  out  2: combinational `testcase - 1` mod 4.

## Operation
- FSM states: IDLE, SHOW, INPUT.
- Internal `armed` flag: set by reset, cleared on entering SHOW.
- IDLE:
  - `led` = 0.
  - Start condition: (`armed` or `compare_turn_finish`) and `testcase` != 0.
  - On start: go to SHOW and load the counter with D = max(1, `LED_CYCLES` >> `reg_score`).
- SHOW:
  - `led` = PATTERN[`testcase`], sampled each cycle.
  - Counter decrements each cycle.
  - When the counter is 1: go to INPUT, load `USER_CYCLES`, pulse `led_is_finish`.
- INPUT:
  - `led` = 0; counter decrements.
  - When the counter is 1: `my_sol` <= `switch`, pulse `user_turn_finish`, go to IDLE.
- `compare_turn_finish` in SHOW or INPUT is ignored and not queued.
- When `testcase` = 0, IDLE never starts a round; `led` stays 0 and no pulses are produced.
- Patterns: PATTERN[3] = 10'h2AA, PATTERN[2] = 10'h0F0, PATTERN[1] = 10'h30F, PATTERN[0] = 10'h000.
- `testcase_next` = `adder_2bit`(a = `testcase`, b = 2'b10, cin = 1).sum. Carry-out is unused.
- `adder_2bit` computes {cout, sum} = a + b + cin, with 2-bit a and b.

## Timing
- Reset values: state IDLE, `armed` = 1, `led` = 0, `my_sol` = 0, both pulses 0, counter 0.
- Reset asserted mid-round aborts the round immediately; after release the block restarts from IDLE with `armed` set.
- First clock edge after reset release (IDLE, `armed`) → SHOW. `led` shows the pattern from the following cycle.
- SHOW lasts exactly D cycles, so `led` is non-zero for exactly D consecutive cycles.
- `led_is_finish` is high during the first INPUT cycle; `led` is 0 in that same cycle.
- INPUT lasts exactly `USER_CYCLES` cycles.
- `user_turn_finish` and the new `my_sol` appear together in the first IDLE cycle after INPUT.
- `switch` is sampled on the edge ending the last INPUT cycle.
- `compare_turn_finish` seen in IDLE → SHOW on the next edge (one-cycle latency).
- If `compare_turn_finish` arrives in the same cycle as `user_turn_finish`, a new round starts.

## Structure
- Shared package holds:
  - the pattern ROM constant `PATTERN[0:3]`;
  - the state enum {IDLE, SHOW, INPUT};
  - the `GAME_OVER` = 2'd0 constant.
- One sub-module: `adder_2bit` (ports a, b, cin, sum, cout), a pure combinational ripple adder.
- Everything else lives in `led_user_turn`: FSM, counter, duration shifter, output registers.

## Test plan
All scenarios use `LED_CYCLES` = 8 and `USER_CYCLES` = 12.
- **Reset start:** `testcase` = 3, `reg_score` = 0; release reset → `led` = 10'h2AA for exactly 8 cycles, then `led_is_finish` pulses once and `led` = 0.
- **Capture:** continue the previous scenario; set `switch` = 10'h155 during INPUT → 12 cycles after `led_is_finish`, `user_turn_finish` pulses once and `my_sol` = 10'h155 and holds.
- **Score scaling:** `testcase` = 2, `reg_score` = 2, pulse `compare_turn_finish` in IDLE → `led` = 10'h0F0 for 2 cycles. With `reg_score` = 3 → 1 cycle (8 >> 3 = 1).
- **Game over:** `testcase` = 0, pulse `compare_turn_finish` → `led` stays 0, no pulses. Check `testcase_next` values 3→2, 1→0, 0→3.
- **Ignored trigger:** pulse `compare_turn_finish` mid-SHOW → SHOW length unchanged, and the block idles after `user_turn_finish` with no extra round.
- **Reset mid-round:** assert `reset` during INPUT → `led` = 0, `my_sol` = 0 immediately. On release, a new SHOW begins after one cycle.
